// File: rtl/ula_pkg.sv
// Shared widths and FSM state encoding for the ULA operand loader.
// The state encoding is visible on the estado LEDs, so it is fixed explicitly.
package ula_pkg;
    localparam int LARGURA     = 6;
    localparam int LARGURA_SEL = 4;

    typedef enum logic [1:0] {
        ESPERA_A   = 2'b00,
        ESPERA_B   = 2'b01,
        ESPERA_SEL = 2'b10,
        VALIDO     = 2'b11
    } estado_t;
endpackage

// File: rtl/ula_condiciona_botao.sv
// Push-button conditioner: 2-FF synchronizer, counting debounce, and a
// one-cycle pulse on each accepted rising level.
module ula_condiciona_botao #(
    parameter int CICLOS_DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic botao,
    output logic pulso
);
    localparam int CW = $clog2(CICLOS_DEBOUNCE + 1);

    logic          sinc1_reg;
    logic          sinc2_reg;
    logic          nivel_reg;
    logic [CW-1:0] cont_reg;

    // The pulse is raised in the same cycle the debounced level flips to 1,
    // giving 2 sync cycles plus CICLOS_DEBOUNCE debounce cycles of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc1_reg <= 1'b0;
            sinc2_reg <= 1'b0;
            nivel_reg <= 1'b0;
            cont_reg  <= '0;
            pulso     <= 1'b0;
        end else begin
            sinc1_reg <= botao;
            sinc2_reg <= sinc1_reg;
            pulso     <= 1'b0;
            if (sinc2_reg != nivel_reg) begin
                if (cont_reg == CW'(CICLOS_DEBOUNCE - 1)) begin
                    nivel_reg <= sinc2_reg;
                    cont_reg  <= '0;
                    pulso     <= sinc2_reg;
                end else begin
                    cont_reg <= cont_reg + 1'b1;
                end
            end else begin
                cont_reg <= '0;
            end
        end
    end
endmodule

// File: rtl/ula_carregador_operandos.sv
// Operand loader for the 6-bit ULA: captures A, B and sel from the shared
// switch bus, one confirm press each, and holds them with a valid/ready pair.
module ula_carregador_operandos
    import ula_pkg::*;
#(
    parameter int CICLOS_DEBOUNCE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LARGURA-1:0]     dado_in,
    input  logic                   btn_confirma,
    input  logic                   btn_cancela,
    input  logic                   ula_pronta,
    output logic [LARGURA-1:0]     A,
    output logic [LARGURA-1:0]     B,
    output logic [LARGURA_SEL-1:0] sel,
    output logic                   operandos_validos,
    output logic [1:0]             estado
);
    // Index 0 is confirma, index 1 is cancela.
    logic [1:0] botoes;
    logic [1:0] pulsos;
    estado_t    estado_reg;

    assign botoes = {btn_cancela, btn_confirma};
    assign estado = estado_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_botao
            ula_condiciona_botao #(
                .CICLOS_DEBOUNCE(CICLOS_DEBOUNCE)
            ) u_cond (
                .clk   (clk),
                .rst_n (rst_n),
                .botao (botoes[gi]),
                .pulso (pulsos[gi])
            );
        end
    endgenerate

    // Cancel is checked first so it overrides confirm and ula_pronta.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg        <= ESPERA_A;
            A                 <= '0;
            B                 <= '0;
            sel               <= '0;
            operandos_validos <= 1'b0;
        end else if (pulsos[1]) begin
            estado_reg        <= ESPERA_A;
            A                 <= '0;
            B                 <= '0;
            sel               <= '0;
            operandos_validos <= 1'b0;
        end else begin
            case (estado_reg)
                ESPERA_A: begin
                    if (pulsos[0]) begin
                        A          <= dado_in;
                        estado_reg <= ESPERA_B;
                    end
                end
                ESPERA_B: begin
                    if (pulsos[0]) begin
                        B          <= dado_in;
                        estado_reg <= ESPERA_SEL;
                    end
                end
                ESPERA_SEL: begin
                    if (pulsos[0]) begin
                        sel               <= dado_in[LARGURA_SEL-1:0];
                        estado_reg        <= VALIDO;
                        operandos_validos <= 1'b1;
                    end
                end
                VALIDO: begin
                    // Operands stay put after hand-off; only the flag drops.
                    if (ula_pronta) begin
                        estado_reg        <= ESPERA_A;
                        operandos_validos <= 1'b0;
                    end
                end
                default: begin
                    estado_reg        <= ESPERA_A;
                    operandos_validos <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ula_carregador_operandos.sv
// Self-checking bench for the ULA operand loader: a reference model pushes the
// expected {A,B,sel,valid,estado} and each test pops and compares it.
module tb_ula_carregador_operandos;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] dado_in;
    logic       btn_confirma;
    logic       btn_cancela;
    logic       ula_pronta;
    logic [5:0] A;
    logic [5:0] B;
    logic [3:0] sel;
    logic       operandos_validos;
    logic [1:0] estado;

    int n_vec = 0;
    int n_err = 0;

    logic [18:0] sb[$];
    logic [18:0] exp_v;
    logic [18:0] got_v;

    logic [5:0] m_a, m_b;
    logic [3:0] m_sel;
    logic       m_valid;
    logic [1:0] m_est;

    always #5 clk = ~clk;

    ula_carregador_operandos #(.CICLOS_DEBOUNCE(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dado_in           (dado_in),
        .btn_confirma      (btn_confirma),
        .btn_cancela       (btn_cancela),
        .ula_pronta        (ula_pronta),
        .A                 (A),
        .B                 (B),
        .sel               (sel),
        .operandos_validos (operandos_validos),
        .estado            (estado)
    );

    function automatic logic [18:0] obs();
        return {A, B, sel, operandos_validos, estado};
    endfunction

    // ---------------- reference model ----------------
    task automatic mdl_push();
        sb.push_back({m_a, m_b, m_sel, m_valid, m_est});
    endtask

    task automatic mdl_clear();
        m_a = 0; m_b = 0; m_sel = 0; m_valid = 0; m_est = 2'b00;
        mdl_push();
    endtask

    task automatic mdl_confirma(input logic [5:0] d);
        case (m_est)
            2'b00: begin m_a = d; m_est = 2'b01; end
            2'b01: begin m_b = d; m_est = 2'b10; end
            2'b10: begin m_sel = d[3:0]; m_valid = 1'b1; m_est = 2'b11; end
            default: ;
        endcase
        mdl_push();
    endtask

    task automatic mdl_pronta();
        if (m_est == 2'b11) begin
            m_est = 2'b00;
            m_valid = 1'b0;
        end
        mdl_push();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [5:0] d, input logic conf, input logic canc, input int hold);
        @(negedge clk);
        dado_in = d;
        btn_confirma = conf;
        btn_cancela = canc;
        repeat (hold) @(negedge clk);
        btn_confirma = 1'b0;
        btn_cancela = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse_pronta();
        @(negedge clk);
        ula_pronta = 1'b1;
        @(negedge clk);
        ula_pronta = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; dado_in = 0; btn_confirma = 0; btn_cancela = 0; ula_pronta = 0;
        mdl_clear();
        repeat (3) @(negedge clk);
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d reset_state got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL reset_state: got %h required %h", got_v, exp_v); end
        rst_n = 1'b1;

        press(6'h2A, 1, 0, 10); mdl_confirma(6'h2A);
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d pre_reset_a got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL pre_reset_a: got %h required %h", got_v, exp_v); end

        press(6'h15, 1, 0, 10); mdl_confirma(6'h15);
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d pre_reset_b got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL pre_reset_b: got %h required %h", got_v, exp_v); end

        // Assert reset between edges and look before the next rising edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        mdl_clear();
        #1;
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d async_reset got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL async_reset: got %h required %h", got_v, exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load();
        int lat;
        bit found;
        // Pulse appears after 6 edges; the FSM registers it on the 7th.
        @(negedge clk);
        dado_in = 6'h2A;
        btn_confirma = 1'b1;
        lat = 0;
        found = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (estado != 2'b00) begin lat = i; found = 1; end
        end
        n_vec++;
        $display("vec %0d confirm_latency got %0d", n_vec, lat);
        if (lat != 7) begin n_err++; $display("FAIL confirm_latency: got %0d edges required 7", lat); end
        repeat (4) @(negedge clk);
        btn_confirma = 1'b0;
        repeat (12) @(negedge clk);
        mdl_confirma(6'h2A);
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d load_a got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL load_a: got %h required %h", got_v, exp_v); end

        press(6'h15, 1, 0, 10); mdl_confirma(6'h15);
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d load_b got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL load_b: got %h required %h", got_v, exp_v); end

        press(6'h08, 1, 0, 10); mdl_confirma(6'h08);
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d load_sel got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL load_sel: got %h required %h", got_v, exp_v); end
    endtask

    task automatic test_valido();
        press(6'h3F, 1, 0, 10); mdl_confirma(6'h3F);
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d valido_hold got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL valido_hold: got %h required %h", got_v, exp_v); end

        pulse_pronta(); mdl_pronta();
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d pronta_release got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL pronta_release: got %h required %h", got_v, exp_v); end
    endtask

    task automatic test_bounce();
        @(negedge clk);
        dado_in = 6'h05;
        for (int i = 0; i < 5; i++) begin
            btn_confirma = 1'b1;
            repeat (2) @(negedge clk);
            btn_confirma = 1'b0;
            repeat (2) @(negedge clk);
        end
        btn_confirma = 1'b1;
        repeat (12) @(negedge clk);
        btn_confirma = 1'b0;
        repeat (12) @(negedge clk);
        mdl_confirma(6'h05);
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d bounce_single got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL bounce_single: got %h required %h", got_v, exp_v); end

        press(6'h00, 0, 1, 10); mdl_clear();
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d cancel_clear got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL cancel_clear: got %h required %h", got_v, exp_v); end
    endtask

    task automatic test_cancel_priority();
        press(6'h07, 1, 0, 10); mdl_confirma(6'h07);
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d prio_load_a got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL prio_load_a: got %h required %h", got_v, exp_v); end

        pulse_pronta(); mdl_pronta();
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d pronta_ignored got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL pronta_ignored: got %h required %h", got_v, exp_v); end

        press(6'h2B, 1, 1, 10); mdl_clear();
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d cancel_wins got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL cancel_wins: got %h required %h", got_v, exp_v); end
    endtask

    task automatic test_sel_width();
        press(6'h01, 1, 0, 10); mdl_confirma(6'h01);
        press(6'h02, 1, 0, 10); mdl_confirma(6'h02);
        press(6'b110111, 1, 0, 10); mdl_confirma(6'b110111);
        void'(sb.pop_front());
        void'(sb.pop_front());
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d sel_upper_ignored got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL sel_upper_ignored: got %h required %h", got_v, exp_v); end

        pulse_pronta(); mdl_pronta();
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d sel_pronta got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL sel_pronta: got %h required %h", got_v, exp_v); end

        press(6'h11, 1, 0, 50); mdl_confirma(6'h11);
        exp_v = sb.pop_front(); got_v = obs(); n_vec++;
        $display("vec %0d long_hold got %h", n_vec, got_v);
        if (got_v !== exp_v) begin n_err++; $display("FAIL long_hold: got %h required %h", got_v, exp_v); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_valido();
        test_bounce();
        test_cancel_priority();
        test_sel_width();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end
endmodule
